// File: rtl/rom_access_arb.sv
// Round-robin two-port arbiter/sequencer in front of a single-port program BRAM.
// Optional write protection of port A is enabled by defining ROM_ARB_WP_EN.
module rom_access_arb #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            A_REQ,
  input  logic [AW-1:0]   A_ADDR,
  input  logic [DW-1:0]   A_WDATA,
  input  logic [DW/8-1:0] A_WREN,
  output logic            A_GNT,
  output logic            A_RVALID,
  output logic [DW-1:0]   A_RDATA,
  input  logic            B_REQ,
  input  logic [AW-1:0]   B_ADDR,
  input  logic [DW-1:0]   B_WDATA,
  input  logic [DW/8-1:0] B_WREN,
  output logic            B_GNT,
  output logic            B_RVALID,
  output logic [DW-1:0]   B_RDATA,
  output logic [AW-1:0]   M_ADDR,
  output logic [DW-1:0]   M_WDATA,
  output logic [DW/8-1:0] M_WREN,
  output logic            M_CS,
  input  logic [DW-1:0]   M_RDATA,
  output logic            WP_ERR
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e            r_last;
  logic [AW-1:0]    r_m_addr;
  logic [DW-1:0]    r_m_wdata;
  logic [DW/8-1:0]  r_m_wren;
  logic             r_m_cs;
  logic             r_tag_v;
  port_e            r_tag_p;
  logic             r_a_rvalid;
  logic             r_b_rvalid;

  logic             w_a_gnt;
  logic             w_b_gnt;
  logic             w_gnt;
  port_e            w_gnt_port;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_wdata;
  logic [DW/8-1:0]  w_sel_wren;
  logic [DW/8-1:0]  w_wren;
  logic             w_is_read;
  logic             w_wp_hit;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!RST) begin
      if (A_REQ && (!B_REQ || r_last == PORT_B)) begin
        w_a_gnt = 1'b1;
      end else if (B_REQ) begin
        w_b_gnt = 1'b1;
      end
    end
    w_gnt       = w_a_gnt | w_b_gnt;
    w_gnt_port  = w_b_gnt ? PORT_B : PORT_A;
    w_sel_addr  = w_b_gnt ? B_ADDR  : A_ADDR;
    w_sel_wdata = w_b_gnt ? B_WDATA : A_WDATA;
    w_sel_wren  = w_b_gnt ? B_WREN  : A_WREN;
    w_wren      = w_wp_hit ? '0 : w_sel_wren;
    // A blocked write still carries a nonzero request WREN, so it never tags a return.
    w_is_read   = w_gnt && (w_sel_wren == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_wren   <= '0;
      r_m_cs     <= 1'b0;
      r_last     <= PORT_B;
      r_tag_v    <= 1'b0;
      r_tag_p    <= PORT_A;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_m_cs <= w_gnt;
      if (w_gnt) begin
        r_m_addr  <= w_sel_addr;
        r_m_wdata <= w_sel_wdata;
        r_m_wren  <= w_wren;
        r_last    <= w_gnt_port;
      end else begin
        r_m_wren <= '0;
      end
      r_tag_v    <= w_is_read;
      r_tag_p    <= w_gnt_port;
      r_a_rvalid <= r_tag_v && (r_tag_p == PORT_A);
      r_b_rvalid <= r_tag_v && (r_tag_p == PORT_B);
    end
  end

`ifdef ROM_ARB_WP_EN
  logic r_wp_err;

  always_comb begin
    w_wp_hit = w_a_gnt && (A_WREN != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wp_err <= 1'b0;
    end else if (w_wp_hit) begin
      r_wp_err <= 1'b1;
    end
  end

  assign WP_ERR = r_wp_err;
`else
  assign w_wp_hit = 1'b0;
  assign WP_ERR   = 1'b0;
`endif

  assign A_GNT    = w_a_gnt;
  assign B_GNT    = w_b_gnt;
  assign M_ADDR   = r_m_addr;
  assign M_WDATA  = r_m_wdata;
  assign M_WREN   = r_m_wren;
  assign M_CS     = r_m_cs;
  assign A_RVALID = r_a_rvalid;
  assign B_RVALID = r_b_rvalid;
  assign A_RDATA  = M_RDATA;
  assign B_RDATA  = M_RDATA;

endmodule

// File: tb/tb_rom_access_arb.sv
// Scoreboard bench for rom_access_arb with a behavioural 4096x32 byte-write BRAM.
module tb_rom_access_arb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        A_REQ = 1'b0, B_REQ = 1'b0;
  logic [11:0] A_ADDR = '0, B_ADDR = '0;
  logic [31:0] A_WDATA = '0, B_WDATA = '0;
  logic [3:0]  A_WREN = '0, B_WREN = '0;
  logic        A_GNT, B_GNT, A_RVALID, B_RVALID, M_CS, WP_ERR;
  logic [31:0] A_RDATA, B_RDATA, M_WDATA;
  logic [31:0] M_RDATA = '0;
  logic [11:0] M_ADDR;
  logic [3:0]  M_WREN;

  rom_access_arb #(.AW(12), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA), .A_WREN(A_WREN),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_WREN(B_WREN),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_WREN(M_WREN), .M_CS(M_CS),
    .M_RDATA(M_RDATA), .WP_ERR(WP_ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory preloads to 0xC0DE0000 | address so untouched reads are predictable.
  logic [31:0] mem [0:4095];
  logic        mem_init = 1'b0;
  always @(posedge CLK) begin
    logic [31:0] w;
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE0000 | i;
      mem_init <= 1'b1;
    end else if (M_CS) begin
      w = mem[M_ADDR];
      M_RDATA <= w;
      for (int b = 0; b < 4; b++) if (M_WREN[b]) w[8*b +: 8] = M_WDATA[8*b +: 8];
      mem[M_ADDR] <= w;
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] data;
    int unsigned due;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops in issue order, checks port, data and arrival cycle.
  always @(negedge CLK) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rvalid: got none expected port %0d data %h due %0d", sbq[0].port, sbq[0].data, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (A_RVALID && B_RVALID) begin
      checks++;
      errors++;
      $display("FAIL dual_rvalid: got both expected one (cycle %0d)", cyc);
    end else if (A_RVALID || B_RVALID) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got port %0d expected none (cycle %0d)", B_RVALID, cyc);
      end else begin
        e = sbq.pop_front();
        chk("rv_port", {31'd0, B_RVALID}, {31'd0, e.port});
        chk("rv_data", B_RVALID ? B_RDATA : A_RDATA, e.data);
        chk("rv_cycle", cyc, e.due);
      end
    end
  end

  task automatic drive(input logic ar, input logic [11:0] aa, input logic [31:0] awd, input logic [3:0] awe,
                       input logic br, input logic [11:0] ba, input logic [31:0] bwd, input logic [3:0] bwe);
    A_REQ = ar; A_ADDR = aa; A_WDATA = awd; A_WREN = awe;
    B_REQ = br; B_ADDR = ba; B_WDATA = bwd; B_WREN = bwe;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic to_neg();
    @(negedge CLK);
  endtask

  task automatic to_next();
    @(posedge CLK);
    #1;
  endtask

  task automatic gnt(input logic ea, input logic eb);
    chk("A_GNT", {31'd0, A_GNT}, {31'd0, ea});
    chk("B_GNT", {31'd0, B_GNT}, {31'd0, eb});
  endtask

  task automatic expect_rd(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.due  = cyc + 2;
    sbq.push_back(e);
  endtask

  initial begin
    // Reset held with both ports requesting.
    to_next();
    drive(1'b1, 12'h001, '0, '0, 1'b1, 12'h002, '0, '0);
    for (int unsigned i = 0; i < 3; i++) begin
      to_neg();
      gnt(1'b0, 1'b0);
      chk("rst_M_CS", {31'd0, M_CS}, 32'd0);
      chk("rst_M_WREN", {28'd0, M_WREN}, 32'd0);
      chk("rst_RVALID", {30'd0, A_RVALID, B_RVALID}, 32'd0);
      chk("rst_WP_ERR", {31'd0, WP_ERR}, 32'd0);
      to_next();
    end
    RST = 1'b0;
    to_neg();
    gnt(1'b1, 1'b0);
    expect_rd(1'b0, 32'hC0DE0001);
    to_next();
    idle();
    to_next();

    // B writes, A reads the same word on the next cycle.
    drive(1'b0, '0, '0, '0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    to_neg();
    gnt(1'b0, 1'b1);
    to_next();
    drive(1'b1, 12'h010, '0, '0, 1'b0, '0, '0, '0);
    to_neg();
    gnt(1'b1, 1'b0);
    chk("wr_M_CS", {31'd0, M_CS}, 32'd1);
    chk("wr_M_ADDR", {20'd0, M_ADDR}, 32'h010);
    chk("wr_M_WDATA", M_WDATA, 32'hDEADBEEF);
    chk("wr_M_WREN", {28'd0, M_WREN}, 32'hF);
    expect_rd(1'b0, 32'hDEADBEEF);
    to_next();
    idle();
    to_neg();
    chk("idle_M_CS", {31'd0, M_CS}, 32'd1);
    chk("rd_M_WREN", {28'd0, M_WREN}, 32'd0);
    to_next();

    // B-only read leaves B as last winner, so the tie sequence starts with A.
    drive(1'b0, '0, '0, '0, 1'b1, 12'h005, '0, '0);
    to_neg();
    gnt(1'b0, 1'b1);
    expect_rd(1'b1, 32'hC0DE0005);
    to_next();
    for (int unsigned i = 0; i < 6; i++) begin
      drive(1'b1, 12'h100 + 12'(i), '0, '0, 1'b1, 12'h200 + 12'(i), '0, '0);
      to_neg();
      if (i % 2 == 0) begin
        gnt(1'b1, 1'b0);
        expect_rd(1'b0, 32'hC0DE0100 + i);
      end else begin
        gnt(1'b0, 1'b1);
        expect_rd(1'b1, 32'hC0DE0200 + i);
      end
      to_next();
    end
    idle();
    to_neg();
    chk("post_tie_M_CS", {31'd0, M_CS}, 32'd1);
    to_next();
    to_neg();
    chk("no_gnt_M_CS", {31'd0, M_CS}, 32'd0);
    chk("no_gnt_M_WREN", {28'd0, M_WREN}, 32'd0);
    chk("hold_M_ADDR", {20'd0, M_ADDR}, 32'h205);
    to_next();

    // Byte-lane write merge.
    drive(1'b0, '0, '0, '0, 1'b1, 12'h020, 32'h11223344, 4'hF);
    to_next();
    drive(1'b0, '0, '0, '0, 1'b1, 12'h020, 32'h000000AA, 4'h1);
    to_neg();
    gnt(1'b0, 1'b1);
    to_next();
    drive(1'b0, '0, '0, '0, 1'b1, 12'h020, '0, '0);
    to_neg();
    gnt(1'b0, 1'b1);
    expect_rd(1'b1, 32'h112233AA);
    to_next();
    idle();
    repeat (3) to_next();

    // Reset the cycle after an A read grant: that read must never return.
    drive(1'b1, 12'h007, '0, '0, 1'b0, '0, '0, '0);
    to_neg();
    gnt(1'b1, 1'b0);
    to_next();
    idle();
    RST = 1'b1;
    to_neg();
    gnt(1'b0, 1'b0);
    to_next();
    RST = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      to_neg();
      chk("drop_A_RVALID", {31'd0, A_RVALID}, 32'd0);
      to_next();
    end

    // Port A write to a word B has initialised, then B reads it back.
    drive(1'b0, '0, '0, '0, 1'b1, 12'h030, 32'h11223344, 4'hF);
    to_neg();
    gnt(1'b0, 1'b1);
    to_next();
    drive(1'b1, 12'h030, 32'h00000055, 4'hF, 1'b0, '0, '0, '0);
    to_neg();
    gnt(1'b1, 1'b0);
    to_next();
    drive(1'b0, '0, '0, '0, 1'b1, 12'h030, '0, '0);
    to_neg();
    gnt(1'b0, 1'b1);
    chk("awr_M_CS", {31'd0, M_CS}, 32'd1);
`ifdef ROM_ARB_WP_EN
    chk("awr_M_WREN", {28'd0, M_WREN}, 32'd0);
    chk("awr_WP_ERR", {31'd0, WP_ERR}, 32'd1);
    expect_rd(1'b1, 32'h11223344);
`else
    chk("awr_M_WREN", {28'd0, M_WREN}, 32'hF);
    chk("awr_WP_ERR", {31'd0, WP_ERR}, 32'd0);
    expect_rd(1'b1, 32'h00000055);
`endif
    to_next();
    idle();
    for (int unsigned i = 0; i < 3; i++) begin
      to_neg();
`ifdef ROM_ARB_WP_EN
      chk("sticky_WP_ERR", {31'd0, WP_ERR}, 32'd1);
`else
      chk("sticky_WP_ERR", {31'd0, WP_ERR}, 32'd0);
`endif
      to_next();
    end

    // Bounded drain of any outstanding expected returns.
    for (int unsigned i = 0; i < 10 && sbq.size() != 0; i++) to_next();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_access_arb.md
# rom_access_arb

Two-port arbiter and sequencer in front of the single-port 4096×32 program-memory BRAM of the Cortex-M0 SoC. It shares the memory between the CPU fetch/data path (port A) and the UART boot-loader (port B). It drives the memory's ADDR/WDATA/WREN/CS pins from registers and returns read data with a fixed latency on the owning port. Arbitration is round-robin per cycle.

## Interface
- AW, 12, word-address width (memory depth 2^AW)
- DW, 32, data width; byte lanes = DW/8
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- A_REQ / B_REQ  in  1  access request; held until granted
- A_ADDR / B_ADDR  in  AW  word address
- A_WDATA / B_WDATA  in  DW  write data
- A_WREN / B_WREN  in  4  byte write enables; 0 = read
- A_GNT / B_GNT  out  1  combinational; request accepted this cycle
- A_RVALID / B_RVALID  out  1  read data valid pulse
- A_RDATA / B_RDATA  out  DW  read data; valid only with RVALID
- M_ADDR  out  AW  to memory ADDR (registered)
- M_WDATA  out  DW  to memory WDATA (registered)
- M_WREN  out  4  to memory WREN (registered)
- M_CS  out  1  to memory CS (registered)
- M_RDATA  in  DW  from memory RDATA (1-cycle synchronous read, no output register)
- WP_ERR  out  1  sticky write-protect violation flag (see Configuration)

## Operation
- Grant rule per cycle: only A requests → A; only B → B; both → port opposite to `last` pointer. `last` updates to the granted port on every grant. Reset value of `last` = B, so A wins the first tie.
- At most one GNT per cycle; GNT = 0 whenever RST = 1.
- Issue stage: on grant, the port's ADDR/WDATA/WREN are registered into M_*, and M_CS = 1 the next cycle. With no grant, M_CS = 0 and M_WREN = 0; M_ADDR/M_WDATA hold their previous values.
- Return pipeline: 2-bit shift tag {valid, port} tracks each read (WREN = 0). The tag is captured at grant, advances to the memory stage with M_CS, and fires RVALID on the tagged port one cycle later with RDATA = M_RDATA.
- Writes complete at GNT; no RVALID for writes.
- Back-to-back: one access per cycle sustained. Ports may interleave freely, and returns stay in issue order.
- A_RDATA/B_RDATA: both may mirror M_RDATA; consumers qualify with RVALID.
- Reset values: M_ADDR = 0, M_WDATA = 0, M_WREN = 0, M_CS = 0, both RVALID = 0, return tags cleared, WP_ERR = 0, `last` = B.
- Reset mid-operation: in-flight reads are dropped and no RVALID is produced. The memory write already issued on M_* in the reset cycle is not retracted.

## Timing
- Cycle t: REQ & GNT.
- Cycle t+1: M_CS/M_ADDR/M_WREN valid at memory.
- Cycle t+2: RVALID = 1, RDATA valid.
- Read latency from grant: 2 cycles, fixed, no stalls.
- Write visible to a read granted at t+1 or later (same address): the read returns the new data.
- Starvation bound: a held request is granted within 2 cycles.

## Configuration
- ROM_ARB_WP_EN defined: port A writes (A_WREN ≠ 0) are granted but converted to no-op reads.
  - M_WREN = 0 and M_CS = 1, with no RVALID returned.
  - WP_ERR sets the cycle after the offending grant and stays set until RST.
  - Port B writes are unaffected.
- Not defined: port A writes pass through normally, and WP_ERR is tied to 0.

## Test plan
- Reset: hold RST 3 cycles with both REQ = 1 → GNTs 0, M_CS = 0, M_WREN = 0, RVALIDs 0. First post-reset tie → A_GNT.
- B writes 0xDEADBEEF to 0x010 (WREN = 0xF), A reads 0x010 next cycle → A_RVALID 2 cycles after A_GNT with A_RDATA = 0xDEADBEEF.
- Both REQ held 6 cycles, all reads → grants alternate A,B,A,B,A,B. RVALIDs arrive in the same order, each 2 cycles after its grant.
- Byte write: B writes 0x11223344 with WREN = 0xF, then 0x000000AA with WREN = 0x1 to 0x020; read → 0x112233AA.
- Reset asserted the cycle after an A read grant → no A_RVALID afterwards.
- With ROM_ARB_WP_EN: A writes 0x55 to 0x030 holding 0x11223344 → M_WREN = 0, WP_ERR = 1 next cycle and sticky, B read of 0x030 → 0x11223344. Without the macro → readback 0x55, WP_ERR = 0.
